// File: rtl/rvfi_monitor_pkg.sv
// Shared definitions for the RVFI retirement monitor: error codes,
// the legal memory-mask encoding and the architectural register width.
package rvfi_monitor_pkg;

  localparam int XLEN = 32;

  // Error codes. A lower code wins when several checks fire in one record.
  localparam logic [15:0] ERR_NONE       = 16'h0000;
  localparam logic [15:0] ERR_TRAP_HALT  = 16'h0101;
  localparam logic [15:0] ERR_ORDER      = 16'h0201;
  localparam logic [15:0] ERR_RD_X0      = 16'h0301;
  localparam logic [15:0] ERR_RS1_X0     = 16'h0302;
  localparam logic [15:0] ERR_RS2_X0     = 16'h0303;
  localparam logic [15:0] ERR_RS1_SHADOW = 16'h0401;
  localparam logic [15:0] ERR_RS2_SHADOW = 16'h0402;
  localparam logic [15:0] ERR_PC_DISCONT = 16'h0501;
  localparam logic [15:0] ERR_PC_ALIGN   = 16'h0502;
  localparam logic [15:0] ERR_MEM_RW     = 16'h0601;
  localparam logic [15:0] ERR_MEM_MASK   = 16'h0602;
  localparam logic [15:0] ERR_MODE       = 16'h0701;

  // Byte-lane masks a naturally aligned byte, halfword or word access can use.
  typedef enum logic [3:0] {
    MASK_NONE = 4'b0000,
    MASK_B0   = 4'b0001,
    MASK_B1   = 4'b0010,
    MASK_B2   = 4'b0100,
    MASK_B3   = 4'b1000,
    MASK_H0   = 4'b0011,
    MASK_H1   = 4'b1100,
    MASK_W    = 4'b1111
  } mem_mask_e;

  // True when the mask is empty or one of the aligned access shapes.
  function automatic logic mask_is_legal(input logic [3:0] mask);
    case (mem_mask_e'(mask))
      MASK_NONE, MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rvfi_shadow_rf.sv
// Shadow copy of x1..x31 with a per-entry known bit. Two combinational
// read ports, one write port; x0 is never stored and always reads unknown.
// Only instantiated when PSP_RVFIMON_REGCHECK_EN is defined.
module rvfi_shadow_rf #(
  parameter int XLEN = rvfi_monitor_pkg::XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rd1_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic            rd1_known,
  input  logic [4:0]      rd2_addr,
  output logic [XLEN-1:0] rd2_data,
  output logic            rd2_known,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_q [1:31];
  logic [31:1]     known_q;
  logic            wr_hit;

  assign wr_hit = wr_en && (wr_addr != 5'd0);

  // Read ports return the pre-update contents; x0 reads as unknown.
  always_comb begin
    rd1_data  = '0;
    rd1_known = 1'b0;
    rd2_data  = '0;
    rd2_known = 1'b0;
    if (rd1_addr != 5'd0) begin
      rd1_data  = regs_q[rd1_addr];
      rd1_known = known_q[rd1_addr];
    end
    if (rd2_addr != 5'd0) begin
      rd2_data  = regs_q[rd2_addr];
      rd2_known = known_q[rd2_addr];
    end
  end

  // Register data write.
  // NOTE: the data array is deliberately not reset; the known bits alone qualify it.
  always_ff @(posedge clock) begin
    if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Known bits: cleared asynchronously, set on the first write of each entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      known_q <= '0;
    end else if (wr_hit) begin
      known_q[wr_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/rvfi_monitor.sv
// RVFI retirement checker. Evaluates one retirement record per valid cycle
// and latches the code of the first architectural violation in errcode,
// which stays sticky until reset.
// Optional feature macro: PSP_RVFIMON_REGCHECK_EN adds a shadow register
// file and the rs1/rs2 read-value checks (0x0401/0x0402).
module rvfi_monitor #(
  parameter int XLEN = rvfi_monitor_pkg::XLEN,
  parameter int NRET = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [31:0]     rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_halt,
  input  logic            rvfi_intr,
  input  logic [1:0]      rvfi_mode,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  input  logic [XLEN-1:0] rvfi_mem_addr,
  input  logic [XLEN-1:0] rvfi_mem_rdata,
  input  logic [XLEN-1:0] rvfi_mem_wdata,
  input  logic [3:0]      rvfi_mem_rmask,
  input  logic [3:0]      rvfi_mem_wmask,
  input  logic            rvfi_mem_extamo,
  output logic [15:0]     errcode
);

  import rvfi_monitor_pkg::*;

  logic [63:0]     exp_order_q;
  logic [XLEN-1:0] last_pc_q;
  logic            first_q;
  logic            rs1_mismatch;
  logic            rs2_mismatch;
  logic [15:0]     err_now;

`ifdef PSP_RVFIMON_REGCHECK_EN
  logic [XLEN-1:0] sh_rs1_data;
  logic [XLEN-1:0] sh_rs2_data;
  logic            sh_rs1_known;
  logic            sh_rs2_known;

  // Every valid record commits its rd write, faulting or not.
  rvfi_shadow_rf #(
    .XLEN (XLEN)
  ) u_shadow_rf (
    .clock     (clock),
    .reset     (reset),
    .rd1_addr  (rvfi_rs1_addr),
    .rd1_data  (sh_rs1_data),
    .rd1_known (sh_rs1_known),
    .rd2_addr  (rvfi_rs2_addr),
    .rd2_data  (sh_rs2_data),
    .rd2_known (sh_rs2_known),
    .wr_en     (rvfi_valid),
    .wr_addr   (rvfi_rd_addr),
    .wr_data   (rvfi_rd_wdata)
  );

  assign rs1_mismatch = sh_rs1_known && (sh_rs1_data != rvfi_rs1_rdata);
  assign rs2_mismatch = sh_rs2_known && (sh_rs2_data != rvfi_rs2_rdata);
`else
  assign rs1_mismatch = 1'b0;
  assign rs2_mismatch = 1'b0;
`endif

  // Instruction word, memory data/address and AMO flag carry no checked rules.
  logic unused_inputs;
  assign unused_inputs = ^{rvfi_insn, rvfi_mem_addr, rvfi_mem_rdata,
                           rvfi_mem_wdata, rvfi_mem_extamo, (NRET != 1)};

  // Priority-ordered violation detection for the current record.
  // NOTE: err_now gets its default before the if-chain, so every path assigns it and no latch is inferred.
  always_comb begin
    err_now = ERR_NONE;
    if (rvfi_trap || rvfi_halt) begin
      err_now = ERR_TRAP_HALT;
    end else if (rvfi_order != exp_order_q) begin
      err_now = ERR_ORDER;
    end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0)) begin
      err_now = ERR_RD_X0;
    end else if ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) begin
      err_now = ERR_RS1_X0;
    end else if ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0)) begin
      err_now = ERR_RS2_X0;
    end else if (rs1_mismatch) begin
      err_now = ERR_RS1_SHADOW;
    end else if (rs2_mismatch) begin
      err_now = ERR_RS2_SHADOW;
    end else if (!first_q && !rvfi_intr && (rvfi_pc_rdata != last_pc_q)) begin
      err_now = ERR_PC_DISCONT;
    end else if ((rvfi_pc_rdata[1:0] != 2'b00) || (rvfi_pc_wdata[1:0] != 2'b00)) begin
      err_now = ERR_PC_ALIGN;
    end else if ((rvfi_mem_rmask != 4'b0000) && (rvfi_mem_wmask != 4'b0000)) begin
      err_now = ERR_MEM_RW;
    end else if (!mask_is_legal(rvfi_mem_rmask) || !mask_is_legal(rvfi_mem_wmask)) begin
      err_now = ERR_MEM_MASK;
    end else if (rvfi_mode == 2'd2) begin
      err_now = ERR_MODE;
    end
  end

  // Retirement tracking and sticky first-error capture.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_order_q <= '0;
      last_pc_q   <= '0;
      first_q     <= 1'b1;
      errcode     <= ERR_NONE;
    end else if (rvfi_valid) begin
      exp_order_q <= exp_order_q + 64'd1;
      last_pc_q   <= rvfi_pc_wdata;
      first_q     <= 1'b0;
      if (errcode == ERR_NONE) begin
        errcode <= err_now;
      end
    end
  end

endmodule

// File: tb/tb_rvfi_monitor.sv
// Self-checking bench for rvfi_monitor: directed scenarios followed by
// randomized record streams, all compared against a behavioural model.
module tb_rvfi_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic        rvfi_mem_extamo;
  logic [15:0] errcode;

  rvfi_monitor dut (
    .clock           (clock),
    .reset           (reset),
    .rvfi_valid      (rvfi_valid),
    .rvfi_order      (rvfi_order),
    .rvfi_insn       (rvfi_insn),
    .rvfi_trap       (rvfi_trap),
    .rvfi_halt       (rvfi_halt),
    .rvfi_intr       (rvfi_intr),
    .rvfi_mode       (rvfi_mode),
    .rvfi_rs1_addr   (rvfi_rs1_addr),
    .rvfi_rs2_addr   (rvfi_rs2_addr),
    .rvfi_rd_addr    (rvfi_rd_addr),
    .rvfi_rs1_rdata  (rvfi_rs1_rdata),
    .rvfi_rs2_rdata  (rvfi_rs2_rdata),
    .rvfi_rd_wdata   (rvfi_rd_wdata),
    .rvfi_pc_rdata   (rvfi_pc_rdata),
    .rvfi_pc_wdata   (rvfi_pc_wdata),
    .rvfi_mem_addr   (rvfi_mem_addr),
    .rvfi_mem_rdata  (rvfi_mem_rdata),
    .rvfi_mem_wdata  (rvfi_mem_wdata),
    .rvfi_mem_rmask  (rvfi_mem_rmask),
    .rvfi_mem_wmask  (rvfi_mem_wmask),
    .rvfi_mem_extamo (rvfi_mem_extamo),
    .errcode         (errcode)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, halt, intr;
    logic [1:0]  mode;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
    logic [31:0] pc_rdata, pc_wdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0]  rmask, wmask;
  } rec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: architectural view of the retirement stream.
  logic [63:0] m_order;
  logic [31:0] m_last_pc;
  bit          m_first;
  logic [31:0] m_reg   [32];
  bit          m_known [32];
  logic [15:0] m_err;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: errcode=0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_order   = 64'd0;
    m_last_pc = 32'd0;
    m_first   = 1'b1;
    m_err     = 16'h0000;
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
  endfunction

  function automatic bit mask_ok(input logic [3:0] m);
    return m inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  endfunction

  // First violated rule, checked in priority order, against pre-record state.
  function automatic logic [15:0] model_code(input rec_t r);
    if (r.trap || r.halt) return 16'h0101;
    if (r.order != m_order) return 16'h0201;
    if (r.rd_addr == 0 && r.rd_wdata != 0) return 16'h0301;
    if (r.rs1_addr == 0 && r.rs1_rdata != 0) return 16'h0302;
    if (r.rs2_addr == 0 && r.rs2_rdata != 0) return 16'h0303;
`ifdef PSP_RVFIMON_REGCHECK_EN
    if (r.rs1_addr != 0 && m_known[r.rs1_addr] && m_reg[r.rs1_addr] != r.rs1_rdata) return 16'h0401;
    if (r.rs2_addr != 0 && m_known[r.rs2_addr] && m_reg[r.rs2_addr] != r.rs2_rdata) return 16'h0402;
`endif
    if (!m_first && !r.intr && r.pc_rdata != m_last_pc) return 16'h0501;
    if (r.pc_rdata[1:0] != 0 || r.pc_wdata[1:0] != 0) return 16'h0502;
    if (r.rmask != 0 && r.wmask != 0) return 16'h0601;
    if (!mask_ok(r.rmask) || !mask_ok(r.wmask)) return 16'h0602;
    if (r.mode == 2'd2) return 16'h0701;
    return 16'h0000;
  endfunction

  function automatic void model_commit(input rec_t r);
    logic [15:0] code;
    code = model_code(r);
    if (m_err == 16'h0000) m_err = code;
    m_order   = m_order + 64'd1;
    m_last_pc = r.pc_wdata;
    m_first   = 1'b0;
    if (r.rd_addr != 0) begin
      m_reg[r.rd_addr]   = r.rd_wdata;
      m_known[r.rd_addr] = 1'b1;
    end
  endfunction

  task automatic apply(input rec_t r);
    rvfi_valid      = r.valid;
    rvfi_order      = r.order;
    rvfi_insn       = r.insn;
    rvfi_trap       = r.trap;
    rvfi_halt       = r.halt;
    rvfi_intr       = r.intr;
    rvfi_mode       = r.mode;
    rvfi_rs1_addr   = r.rs1_addr;
    rvfi_rs2_addr   = r.rs2_addr;
    rvfi_rd_addr    = r.rd_addr;
    rvfi_rs1_rdata  = r.rs1_rdata;
    rvfi_rs2_rdata  = r.rs2_rdata;
    rvfi_rd_wdata   = r.rd_wdata;
    rvfi_pc_rdata   = r.pc_rdata;
    rvfi_pc_wdata   = r.pc_wdata;
    rvfi_mem_addr   = r.mem_addr;
    rvfi_mem_rdata  = r.mem_rdata;
    rvfi_mem_wdata  = r.mem_wdata;
    rvfi_mem_rmask  = r.rmask;
    rvfi_mem_wmask  = r.wmask;
    rvfi_mem_extamo = 1'b0;
  endtask

  // Present one cycle of stimulus, step the model, check one cycle later.
  task automatic send(input rec_t r, input string tag);
    apply(r);
    if (r.valid) model_commit(r);
    @(posedge clock);
    #1;
    check(tag, errcode, m_err);
  endtask

  function automatic rec_t blank_rec();
    rec_t r;
    r = '{valid: 1'b1, order: m_order, insn: 32'h0000_0013, trap: 1'b0, halt: 1'b0,
          intr: 1'b0, mode: 2'd3, rs1_addr: 5'd0, rs2_addr: 5'd0, rd_addr: 5'd0,
          rs1_rdata: 32'd0, rs2_rdata: 32'd0, rd_wdata: 32'd0, pc_rdata: 32'd0,
          pc_wdata: 32'd4, mem_addr: 32'd0, mem_rdata: 32'd0, mem_wdata: 32'd0,
          rmask: 4'd0, wmask: 4'd0};
    return r;
  endfunction

  // A record that obeys every rule given the current model state.
  function automatic rec_t clean_rec();
    rec_t r;
    logic [3:0] legal [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    r = blank_rec();
    r.insn      = $urandom;
    r.pc_rdata  = m_first ? ($urandom & 32'hFFFF_FFFC) : m_last_pc;
    r.pc_wdata  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : r.pc_rdata + 32'd4;
    r.rs1_addr  = 5'($urandom_range(0, 31));
    r.rs2_addr  = 5'($urandom_range(0, 31));
    r.rs1_rdata = (r.rs1_addr == 0) ? 32'd0 : (m_known[r.rs1_addr] ? m_reg[r.rs1_addr] : $urandom);
    r.rs2_rdata = (r.rs2_addr == 0) ? 32'd0 : (m_known[r.rs2_addr] ? m_reg[r.rs2_addr] : $urandom);
    r.rd_addr   = 5'($urandom_range(0, 31));
    r.rd_wdata  = (r.rd_addr == 0) ? 32'd0 : $urandom;
    r.mem_addr  = $urandom;
    r.mem_rdata = $urandom;
    r.mem_wdata = $urandom;
    case ($urandom_range(0, 2))
      1:       r.rmask = legal[$urandom_range(0, 6)];
      2:       r.wmask = legal[$urandom_range(0, 6)];
      default: ;
    endcase
    r.mode = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
    r.intr = ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  // Break one or two rules at random.
  function automatic rec_t add_fault(input rec_t r);
    rec_t f;
    int   base;
    bit   done;
    logic [3:0] m;
    f = r;
    for (int n = 0; n < $urandom_range(1, 2); n++) begin
      case ($urandom_range(0, 11))
        0:  f.trap = 1'b1;
        1:  f.halt = 1'b1;
        2:  f.order = f.order + 64'($urandom_range(1, 5));
        3:  begin f.rd_addr = 5'd0; f.rd_wdata = $urandom | 32'd1; end
        4:  begin f.rs1_addr = 5'd0; f.rs1_rdata = $urandom | 32'd1; end
        5:  begin f.rs2_addr = 5'd0; f.rs2_rdata = $urandom | 32'd1; end
        6:  begin
              base = $urandom_range(1, 31);
              done = 1'b0;
              for (int k = 0; k < 31; k++) begin
                int idx;
                idx = 1 + (base - 1 + k) % 31;
                if (!done && m_known[idx]) begin
                  if ($urandom_range(0, 1) == 1) begin
                    f.rs1_addr = 5'(idx); f.rs1_rdata = m_reg[idx] ^ (32'd1 << $urandom_range(0, 31));
                  end else begin
                    f.rs2_addr = 5'(idx); f.rs2_rdata = m_reg[idx] ^ (32'd1 << $urandom_range(0, 31));
                  end
                  done = 1'b1;
                end
              end
              if (!done) f.trap = 1'b1;
            end
        7:  begin f.pc_rdata = m_last_pc + 32'd8; f.intr = 1'b0; end
        8:  f.pc_wdata = f.pc_wdata | 32'($urandom_range(1, 3));
        9:  begin f.rmask = 4'h1; f.wmask = 4'hF; end
        10: begin
              do m = 4'($urandom_range(5, 14)); while (mask_ok(m));
              if ($urandom_range(0, 1) == 1) f.rmask = m; else f.wmask = m;
            end
        default: f.mode = 2'd2;
      endcase
    end
    return f;
  endfunction

  // Assert reset between clock edges, check the asynchronous clear, release mid-cycle.
  task automatic do_reset(input string tag);
    rec_t r;
    #2;
    reset = 1'b0;
    #1;
    check(tag, errcode, 16'h0000);
    model_reset();
    r = blank_rec();
    r.valid = 1'b0;
    apply(r);
    @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    rec_t r;
    int   since_err;

    model_reset();
    r = blank_rec();
    r.valid = 1'b0;
    apply(r);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", errcode, 16'h0000);
    #2;
    reset = 1'b1;

    // Four clean records along a contiguous PC chain.
    for (int i = 0; i < 4; i++) begin
      r = blank_rec();
      r.order    = 64'(i);
      r.pc_rdata = 32'(4 * i);
      r.pc_wdata = 32'(4 * i + 4);
      send(r, "chain");
      check("chain_zero", errcode, 16'h0000);
    end

    // Order gap: 0 then 2, then sticky through ten clean records.
    do_reset("reset_before_gap");
    r = blank_rec(); r.order = 64'd0; r.pc_rdata = 32'h0; r.pc_wdata = 32'h4;
    send(r, "gap_first");
    r = blank_rec(); r.order = 64'd2; r.pc_rdata = 32'h4; r.pc_wdata = 32'h8;
    send(r, "gap_second");
    check("gap_code", errcode, 16'h0201);
    for (int i = 0; i < 10; i++) send(clean_rec(), "gap_sticky");
    check("gap_held", errcode, 16'h0201);

    // Shadow register read mismatch.
    do_reset("reset_before_regcheck");
    r = blank_rec(); r.rd_addr = 5'd5; r.rd_wdata = 32'h1234;
    send(r, "reg_write");
    r = blank_rec(); r.pc_rdata = 32'h4; r.pc_wdata = 32'h8;
    r.rs1_addr = 5'd5; r.rs1_rdata = 32'h1235;
    send(r, "reg_read");
`ifdef PSP_RVFIMON_REGCHECK_EN
    check("regcheck_code", errcode, 16'h0401);
`else
    check("regcheck_code", errcode, 16'h0000);
`endif

    // PC discontinuity without and with an interrupt entry.
    for (int k = 0; k < 2; k++) begin
      do_reset("reset_before_pc");
      r = blank_rec(); r.pc_rdata = 32'hFC; r.pc_wdata = 32'h100;
      send(r, "pc_first");
      r = blank_rec(); r.pc_rdata = 32'h200; r.pc_wdata = 32'h204; r.intr = (k == 1);
      send(r, "pc_jump");
      check(k == 1 ? "pc_intr_code" : "pc_discont_code", errcode, (k == 1) ? 16'h0000 : 16'h0501);
    end

    // Illegal mask, then rd=x0 write beating reserved mode.
    do_reset("reset_before_mask");
    r = blank_rec(); r.rmask = 4'b0101;
    send(r, "mask_illegal");
    check("mask_code", errcode, 16'h0602);
    do_reset("reset_before_prio");
    r = blank_rec(); r.rd_addr = 5'd0; r.rd_wdata = 32'd1; r.mode = 2'd2;
    send(r, "prio");
    check("prio_code", errcode, 16'h0301);

    // Mid-stream reset after an error, then a fresh first record at a new PC.
    do_reset("reset_midstream");
    r = blank_rec(); r.pc_rdata = 32'h8000; r.pc_wdata = 32'h8004;
    send(r, "after_reset");
    check("after_reset_code", errcode, 16'h0000);

    // Randomized streams with idle gaps, sparse faults and periodic resets.
    since_err = 0;
    for (int i = 0; i < 1500; i++) begin
      int pick;
      pick = $urandom_range(0, 99);
      if (since_err > 4 || pick == 99) begin
        do_reset("rand_reset");
        since_err = 0;
      end
      if (pick < 10) begin
        r = add_fault(clean_rec());
        r.valid = 1'b0;
        send(r, "rand_idle");
      end else if (pick < 16) begin
        send(add_fault(clean_rec()), "rand_fault");
      end else begin
        send(clean_rec(), "rand_clean");
      end
      if (m_err != 16'h0000) since_err++;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
